// File: rtl/wb_arbiter_pkg.sv
// Shared Wishbone B4 types and arbiter state encoding.
package wb_arbiter_pkg;

  typedef enum logic [2:0] {
    WB_CTI_CLASSIC = 3'b000,
    WB_CTI_CONST   = 3'b001,
    WB_CTI_INCR    = 3'b010,
    WB_CTI_EOB     = 3'b111
  } wb_cti_t;

  typedef enum logic [1:0] {
    WB_BTE_LINEAR = 2'b00,
    WB_BTE_WRAP4  = 2'b01,
    WB_BTE_WRAP8  = 2'b10,
    WB_BTE_WRAP16 = 2'b11
  } wb_bte_t;

  // Arbiter FSM encoding kept as plain constants for legacy tools.
  typedef logic [0:0] wb_arb_state_t;
  localparam wb_arb_state_t WB_ARB_IDLE = 1'b0;
  localparam wb_arb_state_t WB_ARB_BUSY = 1'b1;

endpackage

// File: rtl/wb_arbiter_if.sv
// Bundle of the per-master request side and the shared slave side of the arbiter.
// Signal names are from the arbiter's point of view (i_* into it, o_* out of it).
interface wb_arbiter_if
  import wb_arbiter_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32
);

  // Master-facing side
  logic    [NUM_MASTERS-1:0]                 i_m_cyc;
  logic    [NUM_MASTERS-1:0]                 i_m_stb;
  logic    [NUM_MASTERS-1:0]                 i_m_we;
  wb_cti_t [NUM_MASTERS-1:0]                 i_m_cti;
  wb_bte_t [NUM_MASTERS-1:0]                 i_m_bte;
  logic    [NUM_MASTERS-1:0][DATA_W/8-1:0]   i_m_sel;
  logic    [NUM_MASTERS-1:0][ADDR_W-1:0]     i_m_addr;
  logic    [NUM_MASTERS-1:0][DATA_W-1:0]     i_m_data;
  logic    [NUM_MASTERS-1:0]                 o_m_ack;
  logic    [DATA_W-1:0]                      o_m_data;
  logic    [NUM_MASTERS-1:0]                 o_m_gnt;

  // Slave-facing side
  logic                                      o_wb_cyc;
  logic                                      o_wb_stb;
  logic                                      o_wb_we;
  wb_cti_t                                   o_wb_cti;
  wb_bte_t                                   o_wb_bte;
  logic    [DATA_W/8-1:0]                    o_wb_sel;
  logic    [ADDR_W-1:0]                      o_wb_addr;
  logic    [DATA_W-1:0]                      o_wb_data;
  logic                                      i_wb_ack;
  logic    [DATA_W-1:0]                      i_wb_data;

  // Bus masters drive requests and observe ack/data/grant.
  modport master (
    output i_m_cyc, i_m_stb, i_m_we, i_m_cti, i_m_bte, i_m_sel, i_m_addr, i_m_data,
    input  o_m_ack, o_m_data, o_m_gnt
  );

  // The shared slave (sram_top) sees the muxed cycle and answers it.
  modport slave (
    input  o_wb_cyc, o_wb_stb, o_wb_we, o_wb_cti, o_wb_bte, o_wb_sel, o_wb_addr, o_wb_data,
    output i_wb_ack, i_wb_data
  );

  // The arbiter sits between both sides.
  modport arbiter (
    input  i_m_cyc, i_m_stb, i_m_we, i_m_cti, i_m_bte, i_m_sel, i_m_addr, i_m_data,
    output o_m_ack, o_m_data, o_m_gnt,
    output o_wb_cyc, o_wb_stb, o_wb_we, o_wb_cti, o_wb_bte, o_wb_sel, o_wb_addr, o_wb_data,
    input  i_wb_ack, i_wb_data
  );

endinterface

// File: rtl/wb_arbiter_rr_picker.sv
// Combinational round-robin picker: returns the one-hot first requester after last_grant.
// The request vector is concatenated with a copy masked to masters above last_grant;
// the lowest set bit of that double-width word is the winner, folded back to N bits.
module wb_arbiter_rr_picker #(
  parameter int N  = 2,
  parameter int GW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [GW-1:0] last_grant,
  output logic [N-1:0]  winner
);

  localparam int DW2 = 2 * N;

  logic [N-1:0]   upto;
  logic [N-1:0]   served_mask;
  logic [DW2-1:0] dbl;
  logic [DW2-1:0] first;

  // Mask off masters up to and including last_grant, then take the lowest set bit.
  always_comb begin
    upto        = N'(1) << last_grant;
    served_mask = upto | (upto - N'(1));
    dbl         = {req, req & ~served_mask};
    first       = dbl & (~dbl + DW2'(1));
    winner      = first[N-1:0] | first[DW2-1:N];
  end

endmodule

// File: rtl/wb_arbiter.sv
// Round-robin Wishbone B4 arbiter: one tenure per master cycle, one idle cycle between
// tenures, registered one-hot grant, and a sticky ack-timeout watchdog.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int OPTN_NUM_MASTERS    = 2,
  parameter int OPTN_WB_DATA_WIDTH  = 32,
  parameter int OPTN_WB_ADDR_WIDTH  = 32,
  parameter int OPTN_TIMEOUT_CYCLES = 256
) (
  input  logic          i_wb_clk,
  input  logic          i_wb_rst,
  wb_arbiter_if.arbiter bus,
  output logic          o_arb_timeout
);

  localparam int N  = OPTN_NUM_MASTERS;
  localparam int GW = $clog2(N);
  localparam int CW = (OPTN_TIMEOUT_CYCLES > 0) ? $clog2(OPTN_TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] WD_MAX  = CW'(OPTN_TIMEOUT_CYCLES);
  localparam logic [CW-1:0] WD_LAST = CW'(OPTN_TIMEOUT_CYCLES - 1);

  wb_arb_state_t                   state;
  logic [N-1:0]                    gnt;
  logic [N-1:0]                    winner;
  logic [GW-1:0]                   last_grant;
  logic [GW-1:0]                   gnt_idx;
  logic [CW-1:0]                   wd_cnt;
  logic                            busy;
  logic                            release_bus;
  logic [OPTN_WB_DATA_WIDTH/8-1:0] sel_mux;
  logic [OPTN_WB_ADDR_WIDTH-1:0]   addr_mux;
  logic [OPTN_WB_DATA_WIDTH-1:0]   wdata_mux;

  function automatic logic [GW-1:0] onehot_to_idx(input logic [N-1:0] oh);
    logic [GW-1:0] idx;
    idx = '0;
    for (int i = 0; i < N; i++) begin
      if (oh[i]) idx = idx | GW'(i);
    end
    return idx;
  endfunction

  wb_arbiter_rr_picker #(
    .N  (N),
    .GW (GW)
  ) u_picker (
    .req        (bus.i_m_cyc),
    .last_grant (last_grant),
    .winner     (winner)
  );

  assign gnt_idx     = onehot_to_idx(gnt);
  assign busy        = (state == WB_ARB_BUSY);
  assign release_bus = busy && !bus.i_m_cyc[gnt_idx];

  // Grant FSM: latch the round-robin winner in IDLE, hold it until the owner drops cyc.
  always_ff @(posedge i_wb_clk) begin
    if (i_wb_rst) begin
      state      <= WB_ARB_IDLE;
      gnt        <= '0;
      last_grant <= GW'(N - 1);
    end else begin
      case (state)
        WB_ARB_IDLE: begin
          if (|bus.i_m_cyc) begin
            gnt   <= winner;
            state <= WB_ARB_BUSY;
          end
        end
        WB_ARB_BUSY: begin
          if (release_bus) begin
            last_grant <= gnt_idx;
            gnt        <= '0;
            state      <= WB_ARB_IDLE;
          end
        end
        default: begin
          gnt   <= '0;
          state <= WB_ARB_IDLE;
        end
      endcase
    end
  end

  // Slave-side mux driven by the registered grant; everything is zero while idle.
  always_comb begin
    bus.o_wb_cyc = 1'b0;
    bus.o_wb_stb = 1'b0;
    bus.o_wb_we  = 1'b0;
    bus.o_wb_cti = WB_CTI_CLASSIC;
    bus.o_wb_bte = WB_BTE_LINEAR;
    sel_mux      = '0;
    addr_mux     = '0;
    wdata_mux    = '0;
    if (busy) begin
      bus.o_wb_cyc = bus.i_m_cyc[gnt_idx];
      bus.o_wb_stb = bus.i_m_cyc[gnt_idx] & bus.i_m_stb[gnt_idx];
      bus.o_wb_we  = bus.i_m_we[gnt_idx];
      bus.o_wb_cti = bus.i_m_cti[gnt_idx];
      bus.o_wb_bte = bus.i_m_bte[gnt_idx];
      sel_mux      = bus.i_m_sel[gnt_idx];
      addr_mux     = bus.i_m_addr[gnt_idx];
      wdata_mux    = bus.i_m_data[gnt_idx];
    end
    bus.o_wb_sel  = sel_mux;
    bus.o_wb_addr = addr_mux;
    bus.o_wb_data = wdata_mux;
  end

  // Ack only reaches the owner; read data is broadcast.
  always_comb begin
    bus.o_m_ack  = gnt & {N{bus.i_wb_ack}};
    bus.o_m_data = bus.i_wb_data;
    bus.o_m_gnt  = gnt;
  end

  // Watchdog: count stalled strobes in a tenure; the flag latches once the limit is reached.
  always_ff @(posedge i_wb_clk) begin
    if (i_wb_rst) begin
      wd_cnt        <= '0;
      o_arb_timeout <= 1'b0;
    end else if (OPTN_TIMEOUT_CYCLES == 0) begin
      wd_cnt        <= '0;
      o_arb_timeout <= 1'b0;
    end else if (!busy || release_bus || bus.i_wb_ack) begin
      wd_cnt <= '0;
    end else if (bus.o_wb_stb && (wd_cnt != WD_MAX)) begin
      wd_cnt <= wd_cnt + CW'(1);
      if (wd_cnt == WD_LAST) o_arb_timeout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: a 2-master instance for routing, bursts, watchdog and
// reset, and a 3-master instance for round-robin fairness.
module tb_wb_arbiter;
  import wb_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic to2;
  logic to3;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  wb_arbiter_if #(.NUM_MASTERS(2), .DATA_W(32), .ADDR_W(32)) bus2 ();
  wb_arbiter_if #(.NUM_MASTERS(3), .DATA_W(32), .ADDR_W(32)) bus3 ();

  wb_arbiter #(
    .OPTN_NUM_MASTERS(2), .OPTN_WB_DATA_WIDTH(32), .OPTN_WB_ADDR_WIDTH(32),
    .OPTN_TIMEOUT_CYCLES(4)
  ) dut2 (
    .i_wb_clk(clk), .i_wb_rst(rst), .bus(bus2), .o_arb_timeout(to2)
  );

  wb_arbiter #(
    .OPTN_NUM_MASTERS(3), .OPTN_WB_DATA_WIDTH(32), .OPTN_WB_ADDR_WIDTH(32),
    .OPTN_TIMEOUT_CYCLES(4)
  ) dut3 (
    .i_wb_clk(clk), .i_wb_rst(rst), .bus(bus3), .o_arb_timeout(to3)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus2.i_m_cyc = '0; bus2.i_m_stb = '0; bus2.i_m_we = '0;
    bus2.i_m_sel = '0; bus2.i_m_addr = '0; bus2.i_m_data = '0;
    bus2.i_wb_ack = 1'b0; bus2.i_wb_data = '0;
    for (int i = 0; i < 2; i++) begin
      bus2.i_m_cti[i] = WB_CTI_CLASSIC;
      bus2.i_m_bte[i] = WB_BTE_LINEAR;
    end
    bus3.i_m_cyc = '0; bus3.i_m_stb = '0; bus3.i_m_we = '0;
    bus3.i_m_sel = '0; bus3.i_m_addr = '0; bus3.i_m_data = '0;
    bus3.i_wb_ack = 1'b0; bus3.i_wb_data = '0;
    for (int i = 0; i < 3; i++) begin
      bus3.i_m_cti[i] = WB_CTI_CLASSIC;
      bus3.i_m_bte[i] = WB_BTE_LINEAR;
    end
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    tick();
    n_vec++; if (bus2.o_m_gnt !== 2'b00) begin n_err++; $display("FAIL rst_gnt2: got %b want 00", bus2.o_m_gnt); end
    n_vec++; if (bus3.o_m_gnt !== 3'b000) begin n_err++; $display("FAIL rst_gnt3: got %b want 000", bus3.o_m_gnt); end
    n_vec++; if (bus2.o_wb_cyc !== 1'b0) begin n_err++; $display("FAIL rst_cyc: got %b want 0", bus2.o_wb_cyc); end
    n_vec++; if (to2 !== 1'b0) begin n_err++; $display("FAIL rst_timeout: got %b want 0", to2); end
    rst = 1'b0;
    tick();
    n_vec++; if (bus2.o_m_ack !== 2'b00) begin n_err++; $display("FAIL rst_ack: got %b want 00", bus2.o_m_ack); end
    n_vec++; if (bus2.o_wb_addr !== 32'h0) begin n_err++; $display("FAIL rst_addr: got %h want 0", bus2.o_wb_addr); end
  endtask

  task automatic test_single_read();
    do_reset();
    bus2.i_m_cyc[1] = 1'b1; bus2.i_m_stb[1] = 1'b1; bus2.i_m_we[1] = 1'b0;
    bus2.i_m_addr[1] = 32'h100; bus2.i_m_sel[1] = 4'hf;
    #1;
    n_vec++; if (bus2.o_m_gnt !== 2'b00) begin n_err++; $display("FAIL t1_pre_gnt: got %b want 00", bus2.o_m_gnt); end
    n_vec++; if (bus2.o_wb_cyc !== 1'b0) begin n_err++; $display("FAIL t1_pre_cyc: got %b want 0", bus2.o_wb_cyc); end
    tick();
    n_vec++; if (bus2.o_m_gnt !== 2'b10) begin n_err++; $display("FAIL t1_gnt: got %b want 10", bus2.o_m_gnt); end
    n_vec++; if (bus2.o_wb_cyc !== 1'b1 || bus2.o_wb_stb !== 1'b1) begin n_err++; $display("FAIL t1_cycstb: got %b%b want 11", bus2.o_wb_cyc, bus2.o_wb_stb); end
    n_vec++; if (bus2.o_wb_addr !== 32'h100) begin n_err++; $display("FAIL t1_addr: got %h want 100", bus2.o_wb_addr); end
    n_vec++; if (bus2.o_m_ack !== 2'b00) begin n_err++; $display("FAIL t1_ack_c1: got %b want 00", bus2.o_m_ack); end
    tick();
    n_vec++; if (bus2.o_m_ack !== 2'b00) begin n_err++; $display("FAIL t1_ack_c2: got %b want 00", bus2.o_m_ack); end
    bus2.i_wb_ack = 1'b1; bus2.i_wb_data = 32'hCAFEF00D;
    #1;
    n_vec++; if (bus2.o_m_ack !== 2'b10) begin n_err++; $display("FAIL t1_ack_c3: got %b want 10", bus2.o_m_ack); end
    n_vec++; if (bus2.o_m_data !== 32'hCAFEF00D) begin n_err++; $display("FAIL t1_rdata: got %h want cafef00d", bus2.o_m_data); end
    tick();
    bus2.i_wb_ack = 1'b0; bus2.i_m_cyc[1] = 1'b0; bus2.i_m_stb[1] = 1'b0;
    #1;
    n_vec++; if (bus2.o_m_ack !== 2'b00) begin n_err++; $display("FAIL t1_ack_after: got %b want 00", bus2.o_m_ack); end
    n_vec++; if (bus2.o_wb_cyc !== 1'b0) begin n_err++; $display("FAIL t1_cyc_drop: got %b want 0", bus2.o_wb_cyc); end
    tick();
    n_vec++; if (bus2.o_m_gnt !== 2'b00) begin n_err++; $display("FAIL t1_gnt_rel: got %b want 00", bus2.o_m_gnt); end
  endtask

  task automatic test_simultaneous();
    logic [1:0] exp;
    do_reset();
    bus2.i_wb_ack = 1'b1;
    bus2.i_m_cyc = 2'b11; bus2.i_m_stb = 2'b11;
    tick();
    n_vec++; if (bus2.o_m_gnt !== 2'b01) begin n_err++; $display("FAIL t2_first: got %b want 01", bus2.o_m_gnt); end
    bus2.i_m_cyc[0] = 1'b0; bus2.i_m_stb[0] = 1'b0;
    tick();
    n_vec++; if (bus2.o_m_gnt !== 2'b00) begin n_err++; $display("FAIL t2_turnaround: got %b want 00", bus2.o_m_gnt); end
    n_vec++; if (bus2.o_wb_cyc !== 1'b0) begin n_err++; $display("FAIL t2_idle_cyc: got %b want 0", bus2.o_wb_cyc); end
    tick();
    n_vec++; if (bus2.o_m_gnt !== 2'b10) begin n_err++; $display("FAIL t2_second: got %b want 10", bus2.o_m_gnt); end
    bus2.i_m_cyc = 2'b00; bus2.i_m_stb = 2'b00;
    tick();
    for (int r = 0; r < 4; r++) begin
      exp = (r % 2 == 0) ? 2'b01 : 2'b10;
      bus2.i_m_cyc = 2'b11; bus2.i_m_stb = 2'b11;
      tick();
      n_vec++; if (bus2.o_m_gnt !== exp) begin n_err++; $display("FAIL t2_alt%0d: got %b want %b", r, bus2.o_m_gnt, exp); end
      bus2.i_m_cyc = 2'b00; bus2.i_m_stb = 2'b00;
      tick();
      n_vec++; if (bus2.o_m_gnt !== 2'b00) begin n_err++; $display("FAIL t2_idle%0d: got %b want 00", r, bus2.o_m_gnt); end
    end
  endtask

  task automatic test_burst();
    int      acks;
    wb_cti_t exp_cti;
    do_reset();
    acks = 0;
    bus2.i_m_cyc[0] = 1'b1; bus2.i_m_stb[0] = 1'b1;
    bus2.i_m_cti[0] = WB_CTI_INCR; bus2.i_m_bte[0] = WB_BTE_LINEAR;
    bus2.i_m_addr[0] = 32'h200;
    tick();
    n_vec++; if (bus2.o_m_gnt !== 2'b01) begin n_err++; $display("FAIL t3_gnt: got %b want 01", bus2.o_m_gnt); end
    for (int b = 0; b < 8; b++) begin
      exp_cti = (b == 7) ? WB_CTI_EOB : WB_CTI_INCR;
      bus2.i_m_addr[0] = 32'h200 + 32'(4 * b);
      bus2.i_m_cti[0] = exp_cti;
      bus2.i_wb_ack = 1'b1;
      if (b == 3) begin
        bus2.i_m_cyc[1] = 1'b1; bus2.i_m_stb[1] = 1'b1; bus2.i_m_addr[1] = 32'h300;
      end
      #1;
      n_vec++; if (bus2.o_m_ack !== 2'b01) begin n_err++; $display("FAIL t3_ack%0d: got %b want 01", b, bus2.o_m_ack); end
      n_vec++; if (bus2.o_wb_cti !== exp_cti) begin n_err++; $display("FAIL t3_cti%0d: got %0d want %0d", b, bus2.o_wb_cti, exp_cti); end
      n_vec++; if (bus2.o_wb_addr !== 32'h200 + 32'(4 * b)) begin n_err++; $display("FAIL t3_addr%0d: got %h want %h", b, bus2.o_wb_addr, 32'h200 + 32'(4 * b)); end
      if (bus2.o_m_ack[0] === 1'b1) acks++;
      tick();
    end
    bus2.i_m_cyc[0] = 1'b0; bus2.i_m_stb[0] = 1'b0; bus2.i_wb_ack = 1'b0;
    #1;
    n_vec++; if (acks != 8) begin n_err++; $display("FAIL t3_ack_count: got %0d want 8", acks); end
    n_vec++; if (bus2.o_m_gnt !== 2'b01) begin n_err++; $display("FAIL t3_gnt_hold: got %b want 01", bus2.o_m_gnt); end
    n_vec++; if (bus2.o_wb_cyc !== 1'b0) begin n_err++; $display("FAIL t3_cyc_drop: got %b want 0", bus2.o_wb_cyc); end
    tick();
    n_vec++; if (bus2.o_m_gnt !== 2'b00) begin n_err++; $display("FAIL t3_turn: got %b want 00", bus2.o_m_gnt); end
    tick();
    n_vec++; if (bus2.o_m_gnt !== 2'b10) begin n_err++; $display("FAIL t3_m1_gnt: got %b want 10", bus2.o_m_gnt); end
    n_vec++; if (bus2.o_wb_addr !== 32'h300) begin n_err++; $display("FAIL t3_m1_addr: got %h want 300", bus2.o_wb_addr); end
    bus2.i_m_cyc[1] = 1'b0; bus2.i_m_stb[1] = 1'b0;
    tick();
  endtask

  task automatic test_fairness();
    int         last [3];
    int         gi;
    logic [2:0] exp;
    do_reset();
    last = '{-1, -1, -1};
    bus3.i_m_cyc = 3'b111; bus3.i_m_stb = 3'b111; bus3.i_wb_ack = 1'b1;
    for (int t = 0; t < 30; t++) begin
      tick();
      exp = 3'b001 << (t % 3);
      n_vec++; if (bus3.o_m_gnt !== exp) begin n_err++; $display("FAIL t4_gnt%0d: got %b want %b", t, bus3.o_m_gnt, exp); end
      gi = -1;
      for (int i = 0; i < 3; i++) if (bus3.o_m_gnt[i] === 1'b1) gi = i;
      if (gi >= 0) begin
        n_vec++; if (t - last[gi] - 1 > 2) begin n_err++; $display("FAIL t4_wait%0d: got %0d want <=2", t, t - last[gi] - 1); end
        last[gi] = t;
        bus3.i_m_cyc[gi] = 1'b0; bus3.i_m_stb[gi] = 1'b0;
      end
      tick();
      if (gi >= 0) begin
        bus3.i_m_cyc[gi] = 1'b1; bus3.i_m_stb[gi] = 1'b1;
      end
    end
    n_vec++; if (to3 !== 1'b0) begin n_err++; $display("FAIL t4_timeout: got %b want 0", to3); end
    clear_inputs();
    tick();
  endtask

  task automatic test_watchdog();
    logic exp_to;
    do_reset();
    bus2.i_m_cyc[0] = 1'b1; bus2.i_m_stb[0] = 1'b1; bus2.i_m_addr[0] = 32'h400;
    tick();
    n_vec++; if (bus2.o_m_gnt !== 2'b01) begin n_err++; $display("FAIL t5_gnt: got %b want 01", bus2.o_m_gnt); end
    n_vec++; if (to2 !== 1'b0) begin n_err++; $display("FAIL t5_to0: got %b want 0", to2); end
    for (int i = 1; i <= 4; i++) begin
      tick();
      exp_to = (i == 4);
      n_vec++; if (to2 !== exp_to) begin n_err++; $display("FAIL t5_to_stall%0d: got %b want %b", i, to2, exp_to); end
    end
    n_vec++; if (bus2.o_wb_cyc !== 1'b1) begin n_err++; $display("FAIL t5_not_forced: got %b want 1", bus2.o_wb_cyc); end
    tick();
    tick();
    bus2.i_m_cyc[0] = 1'b0; bus2.i_m_stb[0] = 1'b0;
    tick();
    tick();
    n_vec++; if (to2 !== 1'b1) begin n_err++; $display("FAIL t5_sticky: got %b want 1", to2); end
    n_vec++; if (bus2.o_m_gnt !== 2'b00) begin n_err++; $display("FAIL t5_gnt_rel: got %b want 00", bus2.o_m_gnt); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_vec++; if (to2 !== 1'b0) begin n_err++; $display("FAIL t5_to_rst: got %b want 0", to2); end
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    // Short m0 tenure so the rotation pointer points at m0 before the reset.
    bus2.i_wb_ack = 1'b1;
    bus2.i_m_cyc[0] = 1'b1; bus2.i_m_stb[0] = 1'b1;
    tick();
    bus2.i_m_cyc[0] = 1'b0; bus2.i_m_stb[0] = 1'b0;
    tick();
    bus2.i_m_cyc[1] = 1'b1; bus2.i_m_stb[1] = 1'b1;
    bus2.i_m_cti[1] = WB_CTI_INCR; bus2.i_m_addr[1] = 32'h500;
    tick();
    n_vec++; if (bus2.o_m_gnt !== 2'b10) begin n_err++; $display("FAIL t6_gnt_m1: got %b want 10", bus2.o_m_gnt); end
    bus2.i_m_addr[1] = 32'h504;
    tick();
    bus2.i_m_addr[1] = 32'h508;
    bus2.i_m_cyc[0] = 1'b1; bus2.i_m_stb[0] = 1'b1;
    rst = 1'b1;
    tick();
    n_vec++; if (bus2.o_m_gnt !== 2'b00) begin n_err++; $display("FAIL t6_gnt_rst: got %b want 00", bus2.o_m_gnt); end
    n_vec++; if (bus2.o_wb_cyc !== 1'b0) begin n_err++; $display("FAIL t6_cyc_rst: got %b want 0", bus2.o_wb_cyc); end
    n_vec++; if (bus2.o_m_ack !== 2'b00) begin n_err++; $display("FAIL t6_ack_rst: got %b want 00", bus2.o_m_ack); end
    rst = 1'b0;
    tick();
    n_vec++; if (bus2.o_m_gnt !== 2'b01) begin n_err++; $display("FAIL t6_prio: got %b want 01", bus2.o_m_gnt); end
    clear_inputs();
    tick();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_simultaneous();
    test_burst();
    test_fairness();
    test_watchdog();
    test_reset_mid_burst();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
